// File: rtl/adc_readout_ctrl_pkg.sv
// Shared definitions for the ADC readout sequencer: state encodings,
// pipe-word header position and status-word layout.
package adc_readout_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_READY  = 3'd2,
    ST_STREAM = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int HDR_BIT          = 15;
  localparam int STATUS_OVF_BIT   = 15;
  localparam int STATUS_UNF_BIT   = 14;
  localparam int STATUS_STATE_LSB = 2;

  function automatic logic [15:0] pack_status(input logic ovf, input logic unf, input state_e st);
    logic [15:0] s;
    s = '0;
    s[STATUS_OVF_BIT] = ovf;
    s[STATUS_UNF_BIT] = unf;
    s[STATUS_STATE_LSB +: 3] = st;
    return s;
  endfunction

endpackage

// File: rtl/adc_readout_ctrl_sync_2ff.sv
// Two-flop synchroniser for single-bit level signals crossing clock domains.
// Shared by the fifo_full path here and the capture_en path on the ADC side.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_readout_ctrl.sv
// Read-side sequencer for the ADC capture FIFO: arms capture, waits for a full
// block, serves it to the 16-bit pipe-out one word per host read, then drains.
module adc_readout_ctrl
  import adc_readout_ctrl_pkg::*;
#(
  parameter int PRECISION        = 10,
  parameter int FIFO_COUNT_WIDTH = 12,
  parameter int BLOCK_LEN        = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        continuous,
  output logic                        capture_en,
  output logic                        fifo_rd_en,
  input  logic [PRECISION-1:0]        fifo_dout,
  input  logic                        fifo_empty,
  input  logic                        fifo_full,
  input  logic [FIFO_COUNT_WIDTH-1:0] fifo_rd_count,
  input  logic                        pipe_rd,
  output logic [15:0]                 pipe_data,
  output logic                        pipe_ready,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 status
);

  localparam logic [FIFO_COUNT_WIDTH-1:0] BLOCK_LEN_C = FIFO_COUNT_WIDTH'(BLOCK_LEN);

  state_e                      state_q, state_d;
  logic                        cont_q, cont_d;
  logic                        ovf_q, ovf_d;
  logic                        unf_q, unf_d;
  logic                        capture_en_q, capture_en_d;
  logic                        pipe_ready_q, pipe_ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        rd_issued_q, rd_issued_d;
  logic                        hdr_q, hdr_d;
  logic [15:0]                 status_q, status_d;
  logic [FIFO_COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [FIFO_COUNT_WIDTH-1:0] cnt_inc;
  logic                        serving;
  logic                        full_sync;
  logic [15:0]                 pipe_word;

  sync_2ff #(.WIDTH(1)) u_full_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fifo_full),
    .q     (full_sync)
  );

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    ovf_d       = ovf_q | full_sync;
    unf_d       = unf_q;
    word_cnt_d  = word_cnt_q;
    rd_issued_d = 1'b0;
    hdr_d       = 1'b0;
    fifo_rd_en  = 1'b0;
    serving     = (state_q == ST_READY) || (state_q == ST_STREAM);
    cnt_inc     = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + FIFO_COUNT_WIDTH'(1);

    // An empty FIFO still consumes the host read slot; the word goes out as 0.
    if (serving && pipe_rd) begin
      fifo_rd_en  = ~fifo_empty;
      rd_issued_d = ~fifo_empty;
      hdr_d       = (word_cnt_q == '0);
      unf_d       = unf_q | fifo_empty;
      word_cnt_d  = cnt_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ARM;
          cont_d     = continuous;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          word_cnt_d = '0;
        end
      end
      ST_ARM: begin
        if (fifo_rd_count >= BLOCK_LEN_C) state_d = ST_READY;
      end
      ST_READY, ST_STREAM: begin
        if (pipe_rd) begin
          if (cnt_inc >= BLOCK_LEN_C) begin
            state_d    = cont_q ? ST_ARM : ST_FLUSH;
            word_cnt_d = '0;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_FLUSH: begin
        fifo_rd_en = ~fifo_empty;
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) state_d = ST_FLUSH;

    capture_en_d = (state_d == ST_ARM);
    pipe_ready_d = (state_d == ST_READY) || (state_d == ST_STREAM);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    status_d     = pack_status(ovf_d, unf_d, state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cont_q       <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      capture_en_q <= 1'b0;
      pipe_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_issued_q  <= 1'b0;
      hdr_q        <= 1'b0;
      status_q     <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      capture_en_q <= capture_en_d;
      pipe_ready_q <= pipe_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_issued_q  <= rd_issued_d;
      hdr_q        <= hdr_d;
      status_q     <= status_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  // FIFO dout is already a register one cycle after rd_en; only the framing is held here.
  always_comb begin
    pipe_word = '0;
    if (rd_issued_q) begin
      pipe_word[PRECISION-1:0] = fifo_dout;
      pipe_word[HDR_BIT]       = hdr_q;
    end
  end

  assign pipe_data  = pipe_word;
  assign capture_en = capture_en_q;
  assign pipe_ready = pipe_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Directed bench for adc_readout_ctrl with BLOCK_LEN=8 and a behavioural
// standard-mode FIFO model on the read side.
module tb_adc_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic        capture_en;
  logic        fifo_rd_en;
  logic [9:0]  fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_full = 1'b0;
  logic [11:0] fifo_rd_count;
  logic        pipe_rd = 1'b0;
  logic [15:0] pipe_data;
  logic        pipe_ready;
  logic        busy;
  logic        done;
  logic [15:0] status;

  logic [9:0]  mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        cnt_override = 1'b0;
  logic [11:0] cnt_override_val = '0;

  int n_checks = 0;
  int n_fail   = 0;

  adc_readout_ctrl #(
    .PRECISION        (10),
    .FIFO_COUNT_WIDTH (12),
    .BLOCK_LEN        (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .continuous    (continuous),
    .capture_en    (capture_en),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_rd_count (fifo_rd_count),
    .pipe_rd       (pipe_rd),
    .pipe_data     (pipe_data),
    .pipe_ready    (pipe_ready),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  always #5 clk = ~clk;

  // FIFO model: the bench writes via wr_ptr, reads follow fifo_rd_en with dout one cycle later.
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_rd_count = cnt_override ? cnt_override_val : 12'(wr_ptr - rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic p);
    start   = s;
    abort   = a;
    pipe_rd = p;
    #1;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [9:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic start_run(input logic cont);
    continuous = cont;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_read(input string tag, input logic [15:0] exp_data, input logic exp_rd_en, input logic with_abort);
    applyStimulus(1'b0, with_abort, 1'b1);
    checkOutput({tag, "_rd_en"}, 16'(fifo_rd_en), 16'(exp_rd_en));
    step_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_data"}, pipe_data, exp_data);
  endtask

  task automatic wait_for_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      step_cycle();
    end
    checkOutput({tag, "_done"}, 16'(done), 16'h0001);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] Reset state");
    checkOutput("rst_capture_en", 16'(capture_en), 16'h0000);
    checkOutput("rst_busy", 16'(busy), 16'h0000);
    checkOutput("rst_done", 16'(done), 16'h0000);
    checkOutput("rst_pipe_ready", 16'(pipe_ready), 16'h0000);
    checkOutput("rst_pipe_data", pipe_data, 16'h0000);
    checkOutput("rst_status", status, 16'h0000);
    rst_n = 1'b1;
    step_cycle();

    $display("[TB] Test 1: single-shot block");
    start_run(1'b0);
    checkOutput("t1_arm_capture", 16'(capture_en), 16'h0001);
    checkOutput("t1_arm_busy", 16'(busy), 16'h0001);
    checkOutput("t1_arm_status", status, 16'h0004);
    for (int i = 0; i < 8; i++) push_word(10'(i + 1));
    step_cycle();
    checkOutput("t1_ready", 16'(pipe_ready), 16'h0001);
    checkOutput("t1_ready_capture", 16'(capture_en), 16'h0000);
    checkOutput("t1_ready_status", status, 16'h0008);
    for (int i = 0; i < 8; i++)
      do_read("t1_word", (i == 0) ? 16'h8001 : 16'(i + 1), 1'b1, 1'b0);
    checkOutput("t1_flush_status", status, 16'h0010);
    step_cycle();
    checkOutput("t1_done", 16'(done), 16'h0001);
    checkOutput("t1_done_status", status, 16'h0014);
    step_cycle();
    checkOutput("t1_done_pulse_end", 16'(done), 16'h0000);
    checkOutput("t1_idle_busy", 16'(busy), 16'h0000);
    checkOutput("t1_idle_status", status, 16'h0000);

    $display("[TB] Test 2: excess words drained");
    start_run(1'b0);
    for (int i = 0; i < 10; i++) push_word(10'(16'h011 + i));
    step_cycle();
    for (int i = 0; i < 8; i++)
      do_read("t2_word", (i == 0) ? 16'h8011 : 16'(16'h011 + i), 1'b1, 1'b0);
    checkOutput("t2_flush_status", status, 16'h0010);
    checkOutput("t2_flush_rd_en", 16'(fifo_rd_en), 16'h0001);
    step_cycle();
    checkOutput("t2_flush_data_discarded", pipe_data, 16'h0000);
    wait_for_done("t2", 10);
    checkOutput("t2_empty_at_done", 16'(fifo_empty), 16'h0001);
    step_cycle();
    checkOutput("t2_idle_busy", 16'(busy), 16'h0000);

    $display("[TB] Test 3: continuous mode, two blocks, abort with block complete");
    start_run(1'b1);
    for (int i = 0; i < 16; i++) push_word(10'(16'h021 + i));
    step_cycle();
    for (int i = 0; i < 8; i++)
      do_read("t3_b1_word", (i == 0) ? 16'h8021 : 16'(16'h021 + i), 1'b1, 1'b0);
    checkOutput("t3_rearm_status", status, 16'h0004);
    checkOutput("t3_rearm_capture", 16'(capture_en), 16'h0001);
    checkOutput("t3_rearm_no_done", 16'(done), 16'h0000);
    checkOutput("t3_rearm_not_ready", 16'(pipe_ready), 16'h0000);
    do_read("t3_read_in_arm", 16'h0000, 1'b0, 1'b0);
    checkOutput("t3_b2_ready", 16'(pipe_ready), 16'h0001);
    for (int i = 0; i < 8; i++)
      do_read("t3_b2_word", (i == 0) ? 16'h8029 : 16'(16'h029 + i), 1'b1, (i == 7));
    checkOutput("t3_abort_priority_status", status, 16'h0010);
    checkOutput("t3_abort_capture", 16'(capture_en), 16'h0000);
    wait_for_done("t3", 10);
    step_cycle();
    checkOutput("t3_idle_busy", 16'(busy), 16'h0000);

    $display("[TB] Test 4: underflow at word 5");
    start_run(1'b0);
    for (int i = 0; i < 5; i++) push_word(10'(16'h051 + i));
    cnt_override_val = 12'd8;
    cnt_override     = 1'b1;
    step_cycle();
    cnt_override = 1'b0;
    checkOutput("t4_ready", 16'(pipe_ready), 16'h0001);
    for (int i = 0; i < 5; i++)
      do_read("t4_word", (i == 0) ? 16'h8051 : 16'(16'h051 + i), 1'b1, 1'b0);
    do_read("t4_unf_word5", 16'h0000, 1'b0, 1'b0);
    checkOutput("t4_unf_status", status, 16'h400C);
    do_read("t4_unf_word6", 16'h0000, 1'b0, 1'b0);
    do_read("t4_unf_word7", 16'h0000, 1'b0, 1'b0);
    checkOutput("t4_flush_status", status, 16'h4010);
    wait_for_done("t4", 5);
    step_cycle();
    checkOutput("t4_unf_sticky_idle", status, 16'h4000);

    $display("[TB] Test 5: abort at word 3");
    start_run(1'b0);
    checkOutput("t5_unf_cleared", status, 16'h0004);
    for (int i = 0; i < 8; i++) push_word(10'(16'h061 + i));
    step_cycle();
    for (int i = 0; i < 3; i++)
      do_read("t5_word", (i == 0) ? 16'h8061 : 16'(16'h061 + i), 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_abort_status", status, 16'h0010);
    checkOutput("t5_abort_capture", 16'(capture_en), 16'h0000);
    checkOutput("t5_abort_pipe_ready", 16'(pipe_ready), 16'h0000);
    checkOutput("t5_flush_rd_en", 16'(fifo_rd_en), 16'h0001);
    wait_for_done("t5", 12);
    checkOutput("t5_empty_at_done", 16'(fifo_empty), 16'h0001);
    step_cycle();
    checkOutput("t5_idle_busy", 16'(busy), 16'h0000);

    $display("[TB] Test 6: overflow flag");
    fifo_full = 1'b1;
    step_cycle();
    fifo_full = 1'b0;
    checkOutput("t6_ovf_not_yet", status, 16'h0000);
    step_cycle();
    step_cycle();
    checkOutput("t6_ovf_set", status, 16'h8000);
    step_cycle();
    checkOutput("t6_ovf_sticky", status, 16'h8000);
    start_run(1'b0);
    checkOutput("t6_ovf_cleared", status, 16'h0004);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_for_done("t6", 5);
    step_cycle();

    $display("[TB] Test 7: reset mid-stream");
    start_run(1'b0);
    for (int i = 0; i < 8; i++) push_word(10'(16'h071 + i));
    step_cycle();
    do_read("t7_word", 16'h8071, 1'b1, 1'b0);
    do_read("t7_word", 16'h0072, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t7_rst_pipe_data", pipe_data, 16'h0000);
    checkOutput("t7_rst_busy", 16'(busy), 16'h0000);
    checkOutput("t7_rst_pipe_ready", 16'(pipe_ready), 16'h0000);
    checkOutput("t7_rst_status", status, 16'h0000);
    checkOutput("t7_rst_capture", 16'(capture_en), 16'h0000);
    checkOutput("t7_rst_done", 16'(done), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step_cycle();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
